// File: rtl/fpu_ss_pkg.sv
// Shared constants and types for the fpu_ss core multiplexer slice.
package fpu_ss_pkg;

  localparam int NB_CORES_DEFAULT        = 8;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;

  typedef logic [31:0] core_id_t;

  // A single core still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_ss_core_mux_if.sv
// Bundle of the core-side and fpu-side handshake signals around fpu_ss_core_mux.
interface fpu_ss_core_mux_if
  import fpu_ss_pkg::*;
#(
  parameter int NB_CORES  = NB_CORES_DEFAULT,
  parameter int REQ_WIDTH = 96,
  parameter int RES_WIDTH = 64,
  parameter int CNT_WIDTH = $clog2(MAX_OUTSTANDING_DEFAULT + 1)
) ();

  logic [NB_CORES-1:0]                core_req_valid_i;
  logic [NB_CORES-1:0]                core_req_ready_o;
  logic [NB_CORES-1:0][REQ_WIDTH-1:0] core_req_i;
  logic                               fpu_req_valid_o;
  logic                               fpu_req_ready_i;
  logic [REQ_WIDTH-1:0]               fpu_req_o;
  core_id_t                           fpu_req_core_id_o;
  logic                               fpu_res_valid_i;
  logic                               fpu_res_ready_o;
  logic [RES_WIDTH-1:0]               fpu_res_i;
  core_id_t                           fpu_res_core_id_i;
  logic [NB_CORES-1:0]                core_res_valid_o;
  logic [NB_CORES-1:0]                core_res_ready_i;
  logic [RES_WIDTH-1:0]               core_res_o;
  logic [NB_CORES-1:0][CNT_WIDTH-1:0] outstanding_o;
  logic                               err_o;

  // The slave side is the multiplexer itself; the master side is its environment.
  modport slave (
    input  core_req_valid_i, core_req_i, fpu_req_ready_i,
    input  fpu_res_valid_i, fpu_res_i, fpu_res_core_id_i, core_res_ready_i,
    output core_req_ready_o, fpu_req_valid_o, fpu_req_o, fpu_req_core_id_o,
    output fpu_res_ready_o, core_res_valid_o, core_res_o, outstanding_o, err_o
  );

  modport master (
    output core_req_valid_i, core_req_i, fpu_req_ready_i,
    output fpu_res_valid_i, fpu_res_i, fpu_res_core_id_i, core_res_ready_i,
    input  core_req_ready_o, fpu_req_valid_o, fpu_req_o, fpu_req_core_id_o,
    input  fpu_res_ready_o, core_res_valid_o, core_res_o, outstanding_o, err_o
  );

endinterface

// File: rtl/fpu_ss_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module fpu_ss_rr_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int N     = NB_CORES_DEFAULT,
  parameter int PTR_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic [PTR_W-1:0] next_ptr
);

  int   w_idx;
  logic w_found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    next_ptr = ptr;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (en && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = PTR_W'(w_idx);
        next_ptr     = (w_idx == N - 1) ? '0 : PTR_W'(w_idx + 1);
      end
    end
  end

endmodule

// File: rtl/fpu_ss_core_mux.sv
// Shares one fpu_ss among NB_CORES cores: round-robin request issue with core tagging,
// combinational result steering and per-core in-flight limiting.
module fpu_ss_core_mux
  import fpu_ss_pkg::*;
#(
  parameter int NB_CORES        = NB_CORES_DEFAULT,
  parameter int REQ_WIDTH       = 96,
  parameter int RES_WIDTH       = 64,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic              clk_i,
  input logic              rst_ni,
  fpu_ss_core_mux_if.slave bus
);

  localparam int                   PTR_W   = idx_width(NB_CORES);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_req_valid;
  logic [REQ_WIDTH-1:0] r_req;
  core_id_t             r_req_id;
  logic [CNT_WIDTH-1:0] r_cnt [NB_CORES];
  logic                 r_err;

  logic [NB_CORES-1:0]  w_eligible;
  logic [NB_CORES-1:0]  w_gnt;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [PTR_W-1:0]     w_next_ptr;
  logic                 w_accept;
  logic                 w_id_ok;
  logic [PTR_W-1:0]     w_res_idx;
  logic                 w_res_to_core;
  logic                 w_err_next;
  logic [NB_CORES-1:0]  w_dec;
  logic [RES_WIDTH-1:0] w_res;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      w_eligible[i] = bus.core_req_valid_i[i] && (r_cnt[i] < MAX_CNT);
    end
  end

  assign w_accept = !r_req_valid || bus.fpu_req_ready_i;

  fpu_ss_rr_arbiter #(
    .N (NB_CORES)
  ) u_arb (
    .req      (w_eligible),
    .ptr      (r_rr_ptr),
    .en       (w_accept),
    .gnt      (w_gnt),
    .gnt_idx  (w_gnt_idx),
    .next_ptr (w_next_ptr)
  );

  assign bus.core_req_ready_o  = w_gnt;
  assign bus.fpu_req_valid_o   = r_req_valid;
  assign bus.fpu_req_o         = r_req;
  assign bus.fpu_req_core_id_o = r_req_id;

  // A fresh grant always overwrites the register, which also covers drain-and-refill.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req_valid <= 1'b0;
      r_req       <= '0;
      r_req_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (|w_gnt) begin
      r_req_valid <= 1'b1;
      r_req       <= bus.core_req_i[w_gnt_idx];
      r_req_id    <= core_id_t'(w_gnt_idx);
      r_rr_ptr    <= w_next_ptr;
    end else if (r_req_valid && bus.fpu_req_ready_i) begin
      r_req_valid <= 1'b0;
    end
  end

  assign w_id_ok   = bus.fpu_res_core_id_i < core_id_t'(NB_CORES);
  assign w_res_idx = bus.fpu_res_core_id_i[PTR_W-1:0];
  assign w_res     = bus.fpu_res_i;
  assign bus.core_res_o = w_res;

  // Out-of-range IDs are swallowed so a stray result can never stall the fpu.
  always_comb begin
    bus.core_res_valid_o = '0;
    bus.fpu_res_ready_o  = 1'b0;
    w_res_to_core        = 1'b0;
    w_err_next           = 1'b0;
    if (bus.fpu_res_valid_i) begin
      if (w_id_ok) begin
        bus.core_res_valid_o[w_res_idx] = 1'b1;
        bus.fpu_res_ready_o             = bus.core_res_ready_i[w_res_idx];
        w_res_to_core                   = bus.core_res_ready_i[w_res_idx];
        w_err_next = bus.core_res_ready_i[w_res_idx] && (r_cnt[w_res_idx] == '0);
      end else begin
        bus.fpu_res_ready_o = 1'b1;
        w_err_next          = 1'b1;
      end
    end
  end

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      w_dec[i] = w_res_to_core && (w_res_idx == PTR_W'(i)) && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_CORES; i++) r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if (w_gnt[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_gnt[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      r_err <= w_err_next;
    end
  end

  always_comb begin
    bus.outstanding_o = '0;
    for (int i = 0; i < NB_CORES; i++) bus.outstanding_o[i] = r_cnt[i];
  end

  assign bus.err_o = r_err;

endmodule

// File: tb/tb_fpu_ss_core_mux.sv
// Scoreboard bench for fpu_ss_core_mux: a cycle model predicts grants, counters and
// errors, and expected issued requests are queued then popped on fpu-side handshakes.
module tb_fpu_ss_core_mux;

  localparam int NB   = 8;
  localparam int REQW = 96;
  localparam int RESW = 64;
  localparam int MAXO = 4;
  localparam int CNTW = $clog2(MAXO + 1);

  typedef struct {
    logic [REQW-1:0] payload;
    int              id;
  } reqItem_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  fpu_ss_core_mux_if #(.NB_CORES(NB), .REQ_WIDTH(REQW), .RES_WIDTH(RESW), .CNT_WIDTH(CNTW)) bus ();

  fpu_ss_core_mux #(
    .NB_CORES(NB), .REQ_WIDTH(REQW), .RES_WIDTH(RESW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int              nCompared   = 0;
  int              nMismatched = 0;
  int              cycleCount  = 0;
  reqItem_t        expQ [$];
  int              grantLog [$];
  int              mPtr;
  int              mCnt [NB];
  bit              mErr;
  logic [REQW-1:0] reqData [NB];
  logic [RESW-1:0] resData;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  task automatic modelReset();
    mPtr = 0;
    mErr = 1'b0;
    for (int i = 0; i < NB; i++) mCnt[i] = 0;
    expQ.delete();
  endtask

  task automatic applyReset();
    bus.core_req_valid_i  = '0;
    bus.core_req_i        = '0;
    bus.fpu_req_ready_i   = 1'b0;
    bus.fpu_res_valid_i   = 1'b0;
    bus.fpu_res_i         = '0;
    bus.fpu_res_core_id_i = '0;
    bus.core_res_ready_i  = '0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_fpu_valid", bus.fpu_req_valid_o, 0);
    checkOutput("rst_fpu_req", bus.fpu_req_o, 0);
    checkOutput("rst_fpu_id", bus.fpu_req_core_id_o, 0);
    checkOutput("rst_err", bus.err_o, 0);
    checkOutput("rst_outstanding", bus.outstanding_o, 0);
    checkOutput("rst_req_ready", bus.core_req_ready_o, 0);
    checkOutput("rst_res_ready", bus.fpu_res_ready_o, 0);
    checkOutput("rst_res_valid", bus.core_res_valid_o, 0);
    rst_ni = 1'b1;
    modelReset();
  endtask

  // Compare everything against the model at the falling edge, then advance the model.
  task automatic runCycle(input int resId);
    logic [NB-1:0] expGnt;
    logic [NB-1:0] expResValid;
    int            g;
    int            c;
    bit            idOk;
    bit            expResReady;
    bit            hs;
    bit            errNext;
    reqItem_t      popped;
    @(negedge clk_i);
    expGnt = '0;
    g = -1;
    if (expQ.size() == 0 || bus.fpu_req_ready_i) begin
      for (int k = 0; k < NB; k++) begin
        c = (mPtr + k) % NB;
        if (g < 0 && bus.core_req_valid_i[c] && mCnt[c] < MAXO) g = c;
      end
    end
    if (g >= 0) expGnt[g] = 1'b1;
    checkOutput("req_ready", bus.core_req_ready_o, expGnt);
    checkOutput("fpu_valid", bus.fpu_req_valid_o, (expQ.size() != 0));
    if (expQ.size() != 0) begin
      checkOutput("fpu_payload", bus.fpu_req_o, expQ[0].payload);
      checkOutput("fpu_id", bus.fpu_req_core_id_o, expQ[0].id);
    end
    checkOutput("err", bus.err_o, mErr);
    for (int i = 0; i < NB; i++) checkOutput("outstanding", bus.outstanding_o[i], mCnt[i]);

    idOk        = (resId >= 0) && (resId < NB);
    expResValid = '0;
    expResReady = 1'b0;
    if (bus.fpu_res_valid_i) begin
      if (idOk) begin
        expResValid[resId] = 1'b1;
        expResReady = bus.core_res_ready_i[resId];
      end else begin
        expResReady = 1'b1;
      end
      checkOutput("core_res_data", bus.core_res_o, resData);
    end
    checkOutput("core_res_valid", bus.core_res_valid_o, expResValid);
    checkOutput("fpu_res_ready", bus.fpu_res_ready_o, expResReady);
    hs      = bus.fpu_res_valid_i && expResReady;
    errNext = hs && (!idOk || mCnt[resId] == 0);

    if (expQ.size() != 0 && bus.fpu_req_ready_i) begin
      popped = expQ.pop_front();
      grantLog.push_back(popped.id);
    end
    for (int i = 0; i < NB; i++) begin
      if (g == i) mCnt[i]++;
      if (hs && idOk && resId == i && mCnt[i] > 0 && g != i) mCnt[i]--;
      else if (hs && idOk && resId == i && g == i) mCnt[i]--;
    end
    if (g >= 0) begin
      expQ.push_back('{payload: reqData[g], id: g});
      mPtr = (g + 1) % NB;
    end
    mErr = errNext;
    @(posedge clk_i);
    #1;
    cycleCount++;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] vReq, input bit fReady, input bit resValid,
                               input int resId, input logic [NB-1:0] resReady);
    for (int i = 0; i < NB; i++) begin
      reqData[i] = {8'(i), 24'(cycleCount), $urandom, $urandom};
      bus.core_req_i[i] = reqData[i];
    end
    resData               = {$urandom, $urandom};
    bus.core_req_valid_i  = vReq;
    bus.fpu_req_ready_i   = fReady;
    bus.fpu_res_valid_i   = resValid;
    bus.fpu_res_i         = resData;
    bus.fpu_res_core_id_i = 32'(resId);
    bus.core_res_ready_i  = resReady;
    runCycle(resId);
  endtask

  initial begin
    int expOrder [6] = '{0, 3, 5, 0, 3, 5};
    int cyc;

    applyReset();

    // Core 2 back-to-back with the fpu always ready.
    grantLog.delete();
    repeat (3) applyStimulus(8'h04, 1'b1, 1'b0, 0, '0);
    repeat (2) applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    checkOutput("core2_issued", grantLog.size(), 3);
    checkOutput("core2_outstanding", bus.outstanding_o[2], 3);
    repeat (3) applyStimulus(8'h00, 1'b1, 1'b1, 2, 8'h04);
    applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    checkOutput("core2_drained", bus.outstanding_o[2], 0);

    // Cores 0, 3, 5 contend while the fpu stalls two cycles out of three.
    applyReset();
    grantLog.delete();
    cyc = 0;
    while (grantLog.size() < 6 && cyc < 60) begin
      applyStimulus(8'b0010_1001, (cyc % 3 == 0), 1'b0, 0, '0);
      cyc++;
    end
    checkOutput("rr_count", grantLog.size(), 6);
    for (int i = 0; i < 6 && i < grantLog.size(); i++) checkOutput("rr_order", grantLog[i], expOrder[i]);

    // Core 1 hits the in-flight limit, then a returned result frees a slot.
    applyReset();
    repeat (4) applyStimulus(8'h02, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'h02, 1'b1, 1'b0, 0, '0);
    checkOutput("limit_out1", bus.outstanding_o[1], 4);
    applyStimulus(8'h02, 1'b1, 1'b1, 1, 8'h02);
    applyStimulus(8'h02, 1'b1, 1'b0, 0, '0);
    checkOutput("refill_out1", bus.outstanding_o[1], 4);

    // Result for core 4 back-pressured three cycles.
    applyStimulus(8'h10, 1'b1, 1'b0, 0, '0);
    repeat (3) applyStimulus(8'h00, 1'b1, 1'b1, 4, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b1, 4, 8'h10);
    applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    checkOutput("core4_out", bus.outstanding_o[4], 0);

    // Out-of-range ID and result for an idle core both raise err_o.
    applyStimulus(8'h00, 1'b1, 1'b1, 9, 8'hFF);
    applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'h00, 1'b1, 1'b1, 6, 8'h40);
    applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    checkOutput("core6_out", bus.outstanding_o[6], 0);

    // Reset while a request sits stalled; the pointer must restart at core 0.
    applyStimulus(8'h08, 1'b0, 1'b0, 0, '0);
    repeat (2) applyStimulus(8'h00, 1'b0, 1'b0, 0, '0);
    applyReset();
    grantLog.delete();
    applyStimulus(8'h22, 1'b1, 1'b0, 0, '0);
    applyStimulus(8'h00, 1'b1, 1'b0, 0, '0);
    checkOutput("post_rst_count", grantLog.size(), 1);
    if (grantLog.size() > 0) checkOutput("post_rst_grant", grantLog[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
